// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// Shared definitions for the instruction-fetch SRAM-to-AXI read bridge:
// AR state encoding, fixed AXI burst/size codes and the default read ID.
package inst_sram_axi_rd_bridge_pkg;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [3:0] AXI_ID_DEFAULT = 4'd0;

endpackage

// File: rtl/inst_sram_axi_rd_bridge_os_counter.sv
// Saturating up/down counter of reads accepted on the SRAM side but not yet
// returned on R. Simultaneous inc/dec leaves the count unchanged; a decrement
// at zero (protocol error upstream) holds at zero; the count never passes MAX.
module inst_rd_os_counter #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full
);

    localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: saturate at both ends, cancel on simultaneous inc/dec
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            if (cnt_q < CNT_W'(MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full = (cnt_q >= CNT_W'(MAX));

endmodule

// File: rtl/inst_sram_axi_rd_bridge.sv
// Read-only bridge from the IF stage's SRAM-like instruction port to AXI4 AR/R.
// Single ID, single-beat bursts, at most MAX_OUTSTANDING reads in flight.
// Optional build macro INST_BRIDGE_RDATA_REG_EN: when defined the R beat is
// registered before reaching IF (data_ok one cycle after the R handshake);
// when undefined data_ok/rdata are driven straight from rvalid/rdata.
module inst_sram_axi_rd_bridge
    import inst_sram_axi_rd_bridge_pkg::*;
#(
    parameter int         ADDR_W          = 32,
    parameter int         DATA_W          = 32,
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = AXI_ID_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    // SRAM-like instruction port
    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [3:0]        inst_sram_wstrb,
    input  logic [DATA_W-1:0] inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [DATA_W-1:0] inst_sram_rdata,
    // AXI AR channel
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // AXI R channel
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    ar_state_e         ar_state_q;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [2:0]        arsize_q;

    logic addr_ok;
    logic r_hs;
    logic os_full;
    logic rid_match;

    // Writes, strobes, response code and rlast carry no information for a
    // single-beat read-only port; fold them into one sink.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast};

    // IF always has buffer space, so R is never back-pressured
    assign rready    = 1'b1;
    assign r_hs      = rvalid & rready;
    assign rid_match = (rid == AXI_ID);

    // Accept only when the AR slot is free and the in-flight budget allows it;
    // forced low while reset is asserted.
    assign addr_ok = resetn & inst_sram_req & (ar_state_q == AR_IDLE) & ~os_full;
    assign inst_sram_addr_ok = addr_ok;

    inst_rd_os_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_os_counter (
        .clk   (clk),
        .rst_n (resetn),
        .inc   (addr_ok),
        .dec   (r_hs),
        .full  (os_full)
    );

    // AR request FSM: capture payload on accept, hold it until arready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state_q <= AR_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arsize_q   <= '0;
        end else begin
            case (ar_state_q)
                AR_IDLE: begin
                    if (addr_ok) begin
                        araddr_q   <= inst_sram_addr;
                        arsize_q   <= {1'b0, inst_sram_size};
                        arvalid_q  <= 1'b1;
                        ar_state_q <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (arready) begin
                        arvalid_q  <= 1'b0;
                        ar_state_q <= AR_IDLE;
                    end
                end
                default: begin
                    arvalid_q  <= 1'b0;
                    ar_state_q <= AR_IDLE;
                end
            endcase
        end
    end

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = arsize_q;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_q;

`ifdef INST_BRIDGE_RDATA_REG_EN
    logic              data_ok_q;
    logic              data_ok_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Next registered return: take a beat only on a handshake with our ID
    always_comb begin
        data_ok_d = r_hs & rid_match;
        rdata_d   = rdata_q;
        if (r_hs && rid_match) begin
            rdata_d = rdata;
        end
    end

    // Return register; reset drops any beat in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;
`else
    // Zero-latency return; beats with a foreign ID or during reset are dropped
    assign inst_sram_data_ok = resetn & r_hs & rid_match;
    assign inst_sram_rdata   = rdata;
`endif

endmodule
